// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED pattern sequencer: the mode encoding,
// the value each pattern starts from, and helpers that map a mode to its
// entry value and to the mode that follows it.
// No ports (package).

package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  localparam logic [7:0] ENTRY_LEFT  = 8'h01;
  localparam logic [7:0] ENTRY_RIGHT = 8'h80;
  localparam logic [7:0] ENTRY_FILL  = 8'h00;
  localparam logic [7:0] ENTRY_BLINK = 8'h00;

  // Value loaded into the LED bank whenever a mode is entered.
  function automatic logic [7:0] entry_value(input mode_t m);
    logic [7:0] v;
    case (m)
      MODE_LEFT:  v = ENTRY_LEFT;
      MODE_RIGHT: v = ENTRY_RIGHT;
      MODE_FILL:  v = ENTRY_FILL;
      default:    v = ENTRY_BLINK;
    endcase
    return v;
  endfunction

  // Modes cycle LEFT -> RIGHT -> FILL -> BLINK -> LEFT.
  function automatic mode_t next_mode(input mode_t m);
    logic [1:0] n;
    n = 2'(m + 2'd1);
    return mode_t'(n);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// step_prescaler
// Divides the system clock down to a one-cycle step enable that fires
// once every STEP_DIV clocks while not held.
// Ports:
//   CLK     in  system clock, rising edge
//   rs      in  asynchronous active-high reset
//   clr     in  synchronous clear of the count (restarts the step period)
//   hold    in  freezes the count and suppresses step_en
//   step_en out high during the last clock of each period

module step_prescaler #(
  parameter int STEP_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic rs,
  input  logic clr,
  input  logic hold,
  output logic step_en
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  assign step_en = (count == LAST) & ~hold;

  // Count 0..STEP_DIV-1; a clear restarts the period even while held so
  // that a forced mode change always gets a full period before its first step.
  always_ff @(posedge CLK or posedge rs) begin
    if (rs) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (step_en) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
// LED pattern sequencer. Steps one of four patterns (LEFT, RIGHT, FILL,
// BLINK) on an internally generated step enable and moves to the next
// pattern on a mode-button press.
// Optional feature: define LED_SEQ_AUTO_EN to also advance the mode
// automatically after REPEAT completed pattern cycles.
// Ports:
//   CLK      in  system clock, rising edge
//   rs       in  asynchronous active-high reset
//   mode_btn in  conditioned button level; rising edge requests next mode
//   pause    in  freezes the prescaler and the pattern
//   led      out registered LED drive
//   mode     out registered current pattern (0 LEFT,1 RIGHT,2 FILL,3 BLINK)
//   tick     out one-cycle pulse when a newly stepped led value appears

module led_seq_ctrl #(
  parameter int STEP_DIV = 50_000_000,
  parameter int REPEAT   = 2
) (
  input  logic       CLK,
  input  logic       rs,
  input  logic       mode_btn,
  input  logic       pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  import led_seq_pkg::*;

  mode_t      mode_q, mode_d;
  logic [7:0] led_d;
  logic [7:0] step_led;
  logic       fill_up_q, fill_up_d;
  logic       btn_q;
  logic       btn_req;
  logic       step_en;

`ifdef LED_SEQ_AUTO_EN
  localparam int RW = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          cycle_done;
`endif

  assign btn_req = mode_btn & ~btn_q;
  assign mode    = mode_q;

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .CLK     (CLK),
    .rs      (rs),
    .clr     (btn_req),
    .hold    (pause),
    .step_en (step_en)
  );

  // The value the pattern would show after one step from the current led.
  always_comb begin
    step_led = led;
    case (mode_q)
      MODE_LEFT:  step_led = {led[6:0], led[7]};
      MODE_RIGHT: step_led = {led[0], led[7:1]};
      MODE_FILL:  step_led = {led[6:0], fill_up_q};
      default:    step_led = ~led;
    endcase
  end

`ifdef LED_SEQ_AUTO_EN
  // FILL shifting up always sets bit 0, so reaching zero only happens on the way down.
  assign cycle_done = ((mode_q == MODE_LEFT)  && (led == 8'h80)) ||
                      ((mode_q == MODE_RIGHT) && (led == 8'h01)) ||
                      (((mode_q == MODE_FILL) || (mode_q == MODE_BLINK)) && (step_led == 8'h00));
`endif

  // Next-state logic: a button request beats a coincident step, and an
  // auto-advance replaces the completing step's value with the entry value.
  always_comb begin
    mode_d    = mode_q;
    led_d     = led;
    fill_up_d = fill_up_q;
`ifdef LED_SEQ_AUTO_EN
    rpt_d     = rpt_q;
`endif
    if (btn_req) begin
      mode_d    = next_mode(mode_q);
      led_d     = entry_value(mode_d);
      fill_up_d = 1'b1;
`ifdef LED_SEQ_AUTO_EN
      rpt_d     = '0;
`endif
    end else if (step_en) begin
      led_d = step_led;
      if (mode_q == MODE_FILL) begin
        if (fill_up_q && (step_led == 8'hFF)) begin
          fill_up_d = 1'b0;
        end else if (!fill_up_q && (step_led == 8'h00)) begin
          fill_up_d = 1'b1;
        end
      end
`ifdef LED_SEQ_AUTO_EN
      if (cycle_done) begin
        if (rpt_q == RW'(REPEAT - 1)) begin
          mode_d    = next_mode(mode_q);
          led_d     = entry_value(mode_d);
          fill_up_d = 1'b1;
          rpt_d     = '0;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
      end
`endif
    end
  end

  // State register; tick marks only edges where a pattern step was applied.
  always_ff @(posedge CLK or posedge rs) begin
    if (rs) begin
      mode_q    <= MODE_LEFT;
      led       <= ENTRY_LEFT;
      fill_up_q <= 1'b1;
      btn_q     <= 1'b0;
      tick      <= 1'b0;
`ifdef LED_SEQ_AUTO_EN
      rpt_q     <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      led       <= led_d;
      fill_up_q <= fill_up_d;
      btn_q     <= mode_btn;
      tick      <= step_en & ~btn_req;
`ifdef LED_SEQ_AUTO_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl
// Scoreboard bench for led_seq_ctrl with STEP_DIV=4, REPEAT=2. Follows
// LED_SEQ_AUTO_EN the same way the design does.

module tb_led_seq_ctrl;

  localparam int STEP_DIV = 4;
  localparam int REPEAT   = 2;

  logic       CLK = 1'b0;
  logic       rs = 1'b0;
  logic       mode_btn = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] led;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: pattern position as a step index, not as register contents.
  int m_mode = 0;
  int m_k    = 0;
  int m_rep  = 0;
  int m_cnt  = 0;
  bit m_btnq = 1'b0;

  led_seq_ctrl #(.STEP_DIV(STEP_DIV), .REPEAT(REPEAT)) dut (
    .CLK      (CLK),
    .rs       (rs),
    .mode_btn (mode_btn),
    .pause    (pause),
    .led      (led),
    .mode     (mode),
    .tick     (tick)
  );

  always #5 CLK = ~CLK;

  function automatic int period(input int md);
    case (md)
      0, 1:    return 8;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  // LED value after k steps from a mode's entry.
  function automatic logic [7:0] pat_val(input int md, input int k);
    int j;
    int v;
    j = k % period(md);
    case (md)
      0:       v = 1 << j;
      1:       v = 128 >> j;
      2:       v = (j <= 8) ? ((1 << j) - 1) : ((255 << (j - 8)) & 255);
      default: v = (j == 1) ? 255 : 0;
    endcase
    return 8'(v);
  endfunction

  task automatic checkVal(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_tick);
    checkVal({tag, "_led"}, int'(led), int'(pat_val(m_mode, m_k)));
    checkVal({tag, "_mode"}, int'(mode), m_mode);
    checkVal({tag, "_tick"}, int'(tick), int'(exp_tick));
  endtask

  // Drives one clock of inputs (called at a falling edge), advances the
  // model for the coming rising edge and queues any expected stepped value.
  task automatic applyStimulus(input logic btn, input logic pse);
    logic req;
    mode_btn = btn;
    pause    = pse;
    req      = btn && !m_btnq;
    m_btnq   = btn;
    if (req) begin
      m_mode = (m_mode + 1) % 4;
      m_k    = 0;
      m_rep  = 0;
      m_cnt  = 0;
    end else if (!pse) begin
      if (m_cnt == STEP_DIV - 1) begin
        m_cnt = 0;
        m_k++;
        if (m_k % period(m_mode) == 0) begin
          m_k = 0;
`ifdef LED_SEQ_AUTO_EN
          m_rep++;
          if (m_rep == REPEAT) begin
            m_mode = (m_mode + 1) % 4;
            m_rep  = 0;
          end
`endif
        end
        exp_q.push_back('{pat_val(m_mode, m_k), 2'(m_mode)});
      end else begin
        m_cnt++;
      end
    end
    @(posedge CLK);
    #1;
    if (req) checkOutput("button_load", 1'b0);
    else if (pse) checkOutput("paused", 1'b0);
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic doReset();
    #2;
    rs       = 1'b1;
    mode_btn = 1'b0;
    pause    = 1'b0;
    m_mode = 0; m_k = 0; m_rep = 0; m_cnt = 0; m_btnq = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    rs = 1'b0;
    #1;
    checkOutput("reset_state", 1'b0);
  endtask

  // Monitor: every tick must match the oldest expected stepped value.
  always @(negedge CLK) begin
    if (!rs && tick) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_tick: actual led=%0h mode=%0d required no tick", led, mode);
      end else begin
        mon_e = exp_q.pop_front();
        checkVal("tick_led", int'(led), int'(mon_e.led));
        checkVal("tick_mode", int'(mode), int'(mon_e.mode));
      end
    end
  end

  initial begin
    $display("[TB] start STEP_DIV=%0d REPEAT=%0d", STEP_DIV, REPEAT);
    doReset();

    // Free run across two LEFT cycles and into RIGHT.
    repeat (72) applyStimulus(1'b0, 1'b0);

    // Two presses from reset reach FILL, then a full FILL cycle and more.
    doReset();
    repeat (2) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    repeat (70) applyStimulus(1'b0, 1'b0);

    // Button landing on a step edge, then held for 10 cycles.
    for (int i = 0; i < STEP_DIV && m_cnt != STEP_DIV - 1; i++) applyStimulus(1'b0, 1'b0);
    checkVal("align_to_step", m_cnt, STEP_DIV - 1);
    repeat (10) applyStimulus(1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0);

    // Pause for 20 cycles with a press in the middle, then resume.
    repeat (6) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (13) applyStimulus(1'b0, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0);

    // Randomized button and pause activity.
    repeat (400) applyStimulus(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0));

    // Reset while in FILL.
    for (int i = 0; i < 4 && m_mode != 2; i++) begin
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    repeat (14) applyStimulus(1'b0, 1'b0);
    doReset();
    repeat (12) applyStimulus(1'b0, 1'b0);

    #3;
    checkVal("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
